// File: rtl/alu_mc_pkg.sv
// Shared constants for the multi-cycle ALU: default widths, opcode values, FSM states.
// The ALU_MC_DIV_EN macro adds the DIV state used by the divider build.
package alu_mc_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int OPRN_WIDTH_DEF = 6;

    // Only the low nibble carries the opcode; any set upper bit makes it illegal.
    typedef enum logic [3:0] {
        OPC_NONE = 4'h0,
        OPC_ADD  = 4'h1,
        OPC_SUB  = 4'h2,
        OPC_MUL  = 4'h3,
        OPC_SHR  = 4'h4,
        OPC_SHL  = 4'h5,
        OPC_AND  = 4'h6,
        OPC_OR   = 4'h7,
        OPC_NOR  = 4'h8,
        OPC_SLT  = 4'h9,
        OPC_DIVU = 4'hA,
        OPC_REMU = 4'hB
    } opc_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1
`ifdef ALU_MC_DIV_EN
        , S_DIV = 2'd2
`endif
    } state_e;

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative datapath: shift-add multiplier and (with ALU_MC_DIV_EN) restoring divider,
// one bit per cycle, sharing one accumulator/operand register set and an iteration counter.
module alu_mc_iter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_mul,
`ifdef ALU_MC_DIV_EN
    input  logic                  load_div,
    input  logic                  div_mode,
`endif
    input  logic                  step,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic                  last,
    output logic [DATA_WIDTH-1:0] mul_res
`ifdef ALU_MC_DIV_EN
    ,
    output logic [DATA_WIDTH-1:0] div_quo,
    output logic [DATA_WIDTH-1:0] div_rem
`endif
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    // acc: product / partial remainder; x: multiplicand / dividend-quotient; y: multiplier / divisor
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] x_q, x_d;
    logic [DATA_WIDTH-1:0] y_q, y_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mul_sum;
`ifdef ALU_MC_DIV_EN
    logic [DATA_WIDTH:0]   div_shift;
    logic                  div_ok;
    logic [DATA_WIDTH-1:0] rem_nxt;
    logic [DATA_WIDTH-1:0] quo_nxt;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        acc_d   = acc_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        mul_sum = acc_q + (y_q[0] ? x_q : '0);
`ifdef ALU_MC_DIV_EN
        div_shift = {acc_q, x_q[DATA_WIDTH-1]};
        div_ok    = div_shift >= {1'b0, y_q};
        rem_nxt   = div_ok ? DATA_WIDTH'(div_shift - {1'b0, y_q}) : div_shift[DATA_WIDTH-1:0];
        quo_nxt   = {x_q[DATA_WIDTH-2:0], div_ok};
`endif
        last = step && (cnt_q == CNT_W'(DATA_WIDTH - 1));

        if (load_mul) begin
            acc_d = '0;
            x_d   = op_a;
            y_d   = op_b;
            cnt_d = '0;
`ifdef ALU_MC_DIV_EN
        end else if (load_div) begin
            acc_d = '0;
            x_d   = op_a;
            y_d   = op_b;
            cnt_d = '0;
        end else if (step && div_mode) begin
            acc_d = rem_nxt;
            x_d   = quo_nxt;
            cnt_d = last ? '0 : cnt_q + CNT_W'(1);
`endif
        end else if (step) begin
            acc_d = mul_sum;
            x_d   = x_q << 1;
            y_d   = y_q >> 1;
            cnt_d = last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign mul_res = mul_sum;
`ifdef ALU_MC_DIV_EN
    assign div_quo = quo_nxt;
    assign div_rem = rem_nxt;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            x_q   <= x_d;
            y_q   <= y_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: control FSM, single-cycle operations and registered result outputs.
// Define ALU_MC_DIV_EN to build the divu/remu path; otherwise those opcodes are illegal.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int OPRN_WIDTH = OPRN_WIDTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [OPRN_WIDTH-1:0] OPRN,
    input  logic [DATA_WIDTH-1:0] OP1,
    input  logic [DATA_WIDTH-1:0] OP2,
    output logic                  READY,
    output logic                  DONE,
    output logic [DATA_WIDTH-1:0] OUT,
    output logic                  ZERO,
    output logic                  ERR
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  zero_q, zero_d;
    logic                  err_q, err_d;
    logic                  done_q, done_d;
    opc_e                  opc;
    logic                  fin;
    logic [DATA_WIDTH-1:0] fin_val;
    logic                  fin_err;
    logic                  load_mul;
    logic                  iter_last;
    logic [DATA_WIDTH-1:0] mul_res;
`ifdef ALU_MC_DIV_EN
    logic                  rem_sel_q, rem_sel_d;
    logic                  load_div;
    logic [DATA_WIDTH-1:0] div_quo;
    logic [DATA_WIDTH-1:0] div_rem;
`endif

    alu_mc_iter #(.DATA_WIDTH(DATA_WIDTH)) u_iter (
        .clk      (CLK),
        .rst_n    (RST),
        .load_mul (load_mul),
`ifdef ALU_MC_DIV_EN
        .load_div (load_div),
        .div_mode (state_q == S_DIV),
`endif
        .step     (state_q != S_IDLE),
        .op_a     (OP1),
        .op_b     (OP2),
        .last     (iter_last),
        .mul_res  (mul_res)
`ifdef ALU_MC_DIV_EN
        ,
        .div_quo  (div_quo),
        .div_rem  (div_rem)
`endif
    );

    always_comb begin
        opc = OPC_NONE;
        if ((OPRN >> 4) == '0) opc = opc_e'(OPRN[3:0]);
    end

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        zero_d   = zero_q;
        err_d    = err_q;
        done_d   = 1'b0;
        load_mul = 1'b0;
        fin      = 1'b0;
        fin_val  = '0;
        fin_err  = 1'b0;
`ifdef ALU_MC_DIV_EN
        rem_sel_d = rem_sel_q;
        load_div  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    fin = 1'b1;
                    case (opc)
                        OPC_ADD: fin_val = OP1 + OP2;
                        OPC_SUB: fin_val = OP1 - OP2;
                        OPC_SHR: fin_val = OP1 >> OP2;
                        OPC_SHL: fin_val = OP1 << OP2;
                        OPC_AND: fin_val = OP1 & OP2;
                        OPC_OR:  fin_val = OP1 | OP2;
                        OPC_NOR: fin_val = ~(OP1 | OP2);
                        OPC_SLT: fin_val[0] = OP1 < OP2;
                        OPC_MUL: begin
                            fin      = 1'b0;
                            load_mul = 1'b1;
                            state_d  = S_MUL;
                        end
`ifdef ALU_MC_DIV_EN
                        OPC_DIVU, OPC_REMU: begin
                            // A zero divisor finishes at once instead of iterating.
                            if (OP2 == '0) begin
                                fin_val = (opc == OPC_REMU) ? OP1 : '1;
                                fin_err = 1'b1;
                            end else begin
                                fin       = 1'b0;
                                load_div  = 1'b1;
                                rem_sel_d = (opc == OPC_REMU);
                                state_d   = S_DIV;
                            end
                        end
`endif
                        default: fin_err = 1'b1;
                    endcase
                end
            end
            S_MUL: begin
                if (iter_last) begin
                    fin     = 1'b1;
                    fin_val = mul_res;
                    state_d = S_IDLE;
                end
            end
`ifdef ALU_MC_DIV_EN
            S_DIV: begin
                if (iter_last) begin
                    fin     = 1'b1;
                    fin_val = rem_sel_q ? div_rem : div_quo;
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (fin) begin
            done_d = 1'b1;
            out_d  = fin_val;
            zero_d = (fin_val == '0);
            err_d  = fin_err;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            out_q   <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

`ifdef ALU_MC_DIV_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) rem_sel_q <= 1'b0;
        else      rem_sel_q <= rem_sel_d;
    end
`endif

    assign READY = (state_q == S_IDLE);
    assign DONE  = done_q;
    assign OUT   = out_q;
    assign ZERO  = zero_q;
    assign ERR   = err_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed corner cases plus randomized operations
// compared against an arithmetic reference model.
module tb_alu_mc;

    localparam int W = 32;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          START = 1'b0;
    logic [5:0]    OPRN = '0;
    logic [W-1:0]  OP1 = '0;
    logic [W-1:0]  OP2 = '0;
    logic          READY;
    logic          DONE;
    logic [W-1:0]  OUT;
    logic          ZERO;
    logic          ERR;

    int n_checks = 0;
    int n_fails  = 0;

    alu_mc dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .OPRN  (OPRN),
        .OP1   (OP1),
        .OP2   (OP2),
        .READY (READY),
        .DONE  (DONE),
        .OUT   (OUT),
        .ZERO  (ZERO),
        .ERR   (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Result, error flag and DONE latency (cycles after the accepting edge) from the opcode rules.
    function automatic void ref_model(input logic [5:0] opc, input logic [W-1:0] a, input logic [W-1:0] b,
                                      output logic [W-1:0] r, output logic e, output int lat);
        r = '0;
        e = 1'b0;
        lat = 1;
        case (opc)
            6'h01: r = a + b;
            6'h02: r = a - b;
            6'h03: begin r = a * b; lat = W + 1; end
            6'h04: if (b < W) r = a >> b;
            6'h05: if (b < W) r = a << b;
            6'h06: r = a & b;
            6'h07: r = a | b;
            6'h08: r = ~(a | b);
            6'h09: r = (a < b) ? 1 : 0;
`ifdef ALU_MC_DIV_EN
            6'h0A: if (b == 0) begin r = '1; e = 1'b1; end else begin r = a / b; lat = W + 1; end
            6'h0B: if (b == 0) begin r = a;  e = 1'b1; end else begin r = a % b; lat = W + 1; end
`endif
            default: e = 1'b1;
        endcase
    endfunction

    // Called at a falling edge; returns at the falling edge where DONE is seen (or the bound expires).
    task automatic run_op(input string tag, input logic [5:0] opc, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] er;
        logic ee;
        int lat;
        int cyc = 0;
        int busy = 0;
        bit seen = 1'b0;
        ref_model(opc, a, b, er, ee, lat);
        check({tag, ".ready"}, W'(READY), 1);
        START = 1'b1; OPRN = opc; OP1 = a; OP2 = b;
        @(posedge CLK); #1;
        START = 1'b0; OPRN = 6'($urandom); OP1 = $urandom; OP2 = $urandom;
        for (int i = 1; i <= W + 8 && !seen; i++) begin
            @(negedge CLK);
            cyc = i;
            if (DONE) seen = 1'b1;
            else if (!READY) busy++;
        end
        check({tag, ".done_seen"}, W'(seen), 1);
        check({tag, ".latency"}, W'(cyc), W'(lat));
        check({tag, ".busy"}, W'(busy), W'(lat - 1));
        check({tag, ".out"}, OUT, er);
        check({tag, ".zero"}, W'(ZERO), W'(er == 0));
        check({tag, ".err"}, W'(ERR), W'(ee));
    endtask

    initial begin
        logic [5:0] ops [12] = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06,
                                 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h3F};
        logic [W-1:0] a, b;
        logic [5:0] opc;
        int cnt;

        repeat (3) @(negedge CLK);
        check("rst.ready", W'(READY), 1);
        check("rst.done", W'(DONE), 0);
        check("rst.out", OUT, 0);
        check("rst.zero", W'(ZERO), 0);
        check("rst.err", W'(ERR), 0);

        RST = 1'b1;
        run_op("add_wrap", 6'h01, 32'hFFFF_FFFF, 32'h1);
        run_op("mul_spec", 6'h03, 32'h0001_0001, 32'h0001_0001);
        check("mul_spec.const", OUT, 32'h0002_0001);
        run_op("shl_32", 6'h05, 32'h1, 32'd32);
        run_op("shr_31", 6'h04, 32'h8000_0000, 32'd31);
        run_op("slt_3_5", 6'h09, 32'd3, 32'd5);
        run_op("slt_5_3", 6'h09, 32'd5, 32'd3);
        run_op("illegal_3f", 6'h3F, 32'h1234, 32'h5678);
        run_op("illegal_00", 6'h00, 32'h1, 32'h1);
        run_op("divu_100_7", 6'h0A, 32'd100, 32'd7);
        run_op("remu_100_7", 6'h0B, 32'd100, 32'd7);
        run_op("divu_5_0", 6'h0A, 32'd5, 32'd0);
        run_op("remu_5_0", 6'h0B, 32'd5, 32'd0);
        run_op("nor_zero", 6'h08, 32'hFFFF_0000, 32'h0000_FFFF);

        @(negedge CLK);
        check("done_pulse", W'(DONE), 0);

        // START held high through a multiply while operands and opcode keep changing.
        a = $urandom; b = $urandom;
        START = 1'b1; OPRN = 6'h03; OP1 = a; OP2 = b;
        @(posedge CLK); #1;
        cnt = 0;
        for (int i = 1; i <= W; i++) begin
            OPRN = 6'h01; OP1 = $urandom; OP2 = $urandom;
            @(negedge CLK);
            if (DONE) cnt++;
        end
        check("held.early_done", W'(cnt), 0);
        @(negedge CLK);
        START = 1'b0;
        check("held.done", W'(DONE), 1);
        check("held.out", OUT, a * b);
        @(negedge CLK);
        check("held.no_second", W'(DONE), 0);

        // Reset in the middle of a multiply.
        START = 1'b1; OPRN = 6'h03; OP1 = 32'd12345; OP2 = 32'd678;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (10) @(negedge CLK);
        RST = 1'b0;
        #1;
        check("abort.ready", W'(READY), 1);
        check("abort.done", W'(DONE), 0);
        check("abort.out", OUT, 0);
        check("abort.err", W'(ERR), 0);
        @(negedge CLK);
        RST = 1'b1;
        cnt = 0;
        for (int i = 0; i < W + 5; i++) begin
            @(negedge CLK);
            if (DONE) cnt++;
        end
        check("abort.no_done", W'(cnt), 0);
        run_op("add_2_3", 6'h01, 32'd2, 32'd3);

        for (int n = 0; n < 40; n++) begin
            int sel = $urandom_range(0, 13);
            opc = (sel < 12) ? ops[sel] : 6'($urandom);
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom_range(0, 40);
                1: b = '0;
                default: b = $urandom;
            endcase
            run_op($sformatf("rand%0d_op%0h", n, opc), opc, a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
